uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter that serialises bytes offered on a valid/ready input into standard asynchronous frames on a single TX pin. It is the general-purpose successor to the fixed-message transmitter. Baud divider, data width, parity and stop-bit count are set by parameters, and it accepts arbitrary data from an upstream producer such as a message ROM sequencer or a host register. The block sits directly in front of the chip's TX output pin and also drives a per-frame trigger pulse for scope or logic-analyser sync.

## Interface
- CLKS_PER_BIT, default 1: clock cycles per UART bit, ≥1. With the default, the design clock is the baud clock.
- DATA_BITS, default 8: data bits per frame, legal range 5–8.
- PARITY, default 0: 0 = none, 1 = odd, 2 = even. Other values behave as 0.
- STOP_BITS, default 1: stop bits per frame, 1 or 2.

Ports:
- clk  in  1  sole clock; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  DATA_BITS  byte to send; sampled only on an accepting edge.
- valid  in  1  producer has data.
- ready  out  1  block can accept; high exactly when state is IDLE.
- tx_pin  out  1  serial line, registered, idle high.
- trig  out  1  one-cycle pulse marking frame completion.

## Operation
- State machine: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE.
- Reset has priority over every other input.
  - Reset values: state=IDLE, tx_pin=1, ready=1, trig=0, baud and bit counters 0.
  - valid is ignored while reset is high.
  - Reset mid-frame aborts the frame: tx_pin returns high on the next edge and no trig is produced.
- Accept: on an edge where ready & valid & !reset:
  - data is latched into the shift register;
  - state becomes START, tx_pin becomes 0, ready becomes 0.
  - After acceptance, data and valid are don't-care until ready returns.
- Bit timing: each state lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is max(1, clog2(CLKS_PER_BIT)).
- DATA: bits are sent LSB first. The bit counter runs 0..DATA_BITS-1 and wraps to 0 on leaving DATA.
- PARITY bit:
  - even: XOR of the latched data bits;
  - odd: the inverse of that XOR.
  - Parity is computed from the latched copy, not from the live data input.
- STOP: tx_pin=1 for STOP_BITS × CLKS_PER_BIT cycles.
- Frame end: on the edge that ends the last stop cycle:
  - state becomes IDLE, ready becomes 1, trig becomes 1 for one cycle;
  - tx_pin stays 1.
- trig is 0 at all other times.

## Timing
- Accept-to-line latency: tx_pin goes low on the accepting edge itself, so the start bit is visible in the first cycle after acceptance.
- Frame length after acceptance: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- IDLE always lasts at least one clock between frames, because acceptance can only occur in IDLE.
  - With valid held high, start bits are (frame length + 1) cycles apart.
  - Defaults give 11 cycles, i.e. idle, start, 8 data, stop.
- trig is high during the first IDLE cycle after a frame. That is the same cycle in which ready is high and a back-to-back accept can occur.
- All outputs are registered. ready is a registered decode of state, with no combinational path from valid or data to any output.

## Test plan
- Reset then idle: hold reset 3 cycles, then valid=0 for 20 cycles → tx_pin=1, ready=1 and trig=0 throughout, including during reset.
- Defaults, send 0x54: pulse valid once → tx_pin over the next 10 cycles reads 0, 0,0,1,0,1,0,1,0, 1. Then ready=1 and trig=1 for one cycle, and tx_pin stays 1.
- Back-to-back, defaults: valid held high with data 0x54 then 0x69 → second start bit exactly 11 cycles after the first. Second data bits read 1,0,0,1,0,1,1,0. Exactly two trig pulses.
- Parity and stop bits, CLKS_PER_BIT=4, PARITY=2, STOP_BITS=2, send 0x54:
  - each level is held exactly 4 cycles;
  - parity bit is 1;
  - frame is 48 cycles, then ready is asserted.
  - Repeat with PARITY=1 → parity bit is 0.
- DATA_BITS=7, send 0x7F: exactly 7 high data bits, then stop. Total frame is 9 bit-times.
- Reset mid-frame: assert reset during data bit 3 of a 0x00 frame → tx_pin=1 on the next edge, ready=1, no trig. A new frame sent after release is bit-exact.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: valid/ready byte input, one registered TX line,
// and a one-cycle trig pulse in the first idle cycle after each frame.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx_pin,
  output logic                 trig
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [BIT_W-1:0]      bit_inc;
  logic [DATA_BITS-1:0]  data_q;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  trig_q, trig_d;
  logic                  load;
  logic                  baud_wrap;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  assign baud_wrap = (baud_q == BAUD_LAST);
  assign bit_inc   = bit_q + BIT_W'(1);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    trig_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          load    = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = data_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = S_PARITY;
              tx_d    = parity_bit(data_q);
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_inc;
            tx_d  = data_q[bit_inc];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            trig_d  = 1'b1;
          end else begin
            bit_d = bit_inc;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      trig_q  <= trig_d;
    end
  end

  // Latched payload is don't-care outside a frame, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) data_q <= data;
  end

  assign ready  = ready_q;
  assign tx_pin = tx_q;
  assign trig   = trig_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: defaults, back-to-back, parity/stop variants,
// 7-bit data and mid-frame reset, each checked against hand-derived line levels.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] data_def = '0;
  logic       valid_def = 1'b0;
  logic       ready_def, tx_def, trig_def;

  logic [7:0] data_pe = '0;
  logic       valid_pe = 1'b0;
  logic       ready_pe, tx_pe, trig_pe;

  logic [7:0] data_po = '0;
  logic       valid_po = 1'b0;
  logic       ready_po, tx_po, trig_po;

  logic [6:0] data_d7 = '0;
  logic       valid_d7 = 1'b0;
  logic       ready_d7, tx_d7, trig_d7;

  uart_tx_frame u_def (
    .clk(clk), .reset(reset), .data(data_def), .valid(valid_def),
    .ready(ready_def), .tx_pin(tx_def), .trig(trig_def)
  );

  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_pe (
    .clk(clk), .reset(reset), .data(data_pe), .valid(valid_pe),
    .ready(ready_pe), .tx_pin(tx_pe), .trig(trig_pe)
  );

  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_po (
    .clk(clk), .reset(reset), .data(data_po), .valid(valid_po),
    .ready(ready_po), .tx_pin(tx_po), .trig(trig_po)
  );

  uart_tx_frame #(.DATA_BITS(7)) u_d7 (
    .clk(clk), .reset(reset), .data(data_d7), .valid(valid_d7),
    .ready(ready_d7), .tx_pin(tx_d7), .trig(trig_d7)
  );

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_def, ready_def, trig_def} !== 3'b110) begin
        errors++;
        $display("FAIL reset_hold[%0d] tx/ready/trig=%b expected 110", i, {tx_def, ready_def, trig_def});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_def, ready_def, trig_def} !== 3'b110) begin
        errors++;
        $display("FAIL reset_idle[%0d] tx/ready/trig=%b expected 110", i, {tx_def, ready_def, trig_def});
      end
    end
    checks++;
    if ({tx_pe, ready_pe, tx_po, ready_po, tx_d7, ready_d7} !== 6'b111111) begin
      errors++;
      $display("FAIL reset_others tx/ready pairs=%b expected 111111",
               {tx_pe, ready_pe, tx_po, ready_po, tx_d7, ready_d7});
    end
  endtask

  task automatic test_default_frame();
    logic [9:0] exp;
    exp = {1'b1, 8'h54, 1'b0};
    data_def  = 8'h54;
    valid_def = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_def = 1'b0;
      checks++;
      if (tx_def !== exp[i] || ready_def !== 1'b0 || trig_def !== 1'b0) begin
        errors++;
        $display("FAIL default_bit[%0d] tx=%b ready=%b trig=%b expected tx=%b ready=0 trig=0",
                 i, tx_def, ready_def, trig_def, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({tx_def, ready_def, trig_def} !== 3'b111) begin
      errors++;
      $display("FAIL default_end tx/ready/trig=%b expected 111", {tx_def, ready_def, trig_def});
    end
    @(negedge clk);
    checks++;
    if ({tx_def, ready_def, trig_def} !== 3'b110) begin
      errors++;
      $display("FAIL default_after tx/ready/trig=%b expected 110", {tx_def, ready_def, trig_def});
    end
  endtask

  task automatic test_back_to_back();
    logic tx_log [0:29];
    logic rdy_log [0:29];
    logic [7:0] exp2;
    int trig_cnt;
    int s1, s2;
    trig_cnt = 0;
    s1 = -1;
    s2 = -1;
    exp2 = 8'h69;
    data_def  = 8'h54;
    valid_def = 1'b1;
    tx_log[0]  = tx_def;
    rdy_log[0] = ready_def;
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      tx_log[i]  = tx_def;
      rdy_log[i] = ready_def;
      if (trig_def === 1'b1) trig_cnt++;
      if (i == 1) data_def = 8'h69;
      if (i == 12) valid_def = 1'b0;
    end
    for (int i = 1; i < 30; i++) begin
      if (rdy_log[i-1] === 1'b1 && rdy_log[i] === 1'b0) begin
        if (s1 < 0) s1 = i;
        else if (s2 < 0) s2 = i;
      end
    end
    checks++;
    if (s1 != 1) begin
      errors++;
      $display("FAIL b2b_first_start at=%0d expected 1", s1);
    end
    checks++;
    if (s2 - s1 != 11) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d expected 11", s2 - s1);
    end
    if (s2 > 0 && s2 + 9 < 30) begin
      checks++;
      if (tx_log[s2] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_start2 tx=%b expected 0", tx_log[s2]);
      end
      for (int b = 0; b < 8; b++) begin
        checks++;
        if (tx_log[s2 + 1 + b] !== exp2[b]) begin
          errors++;
          $display("FAIL b2b_data2[%0d] tx=%b expected %b", b, tx_log[s2 + 1 + b], exp2[b]);
        end
      end
      checks++;
      if (tx_log[s2 + 9] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stop2 tx=%b expected 1", tx_log[s2 + 9]);
      end
    end
    checks++;
    if (trig_cnt != 2) begin
      errors++;
      $display("FAIL b2b_trig_count got=%0d expected 2", trig_cnt);
    end
  endtask

  task automatic test_parity_even();
    logic [11:0] exp;
    exp = {2'b11, 1'b1, 8'h54, 1'b0};
    data_pe  = 8'h54;
    valid_pe = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      valid_pe = 1'b0;
      checks++;
      if (tx_pe !== exp[i/4] || ready_pe !== 1'b0 || trig_pe !== 1'b0) begin
        errors++;
        $display("FAIL even_cycle[%0d] tx=%b ready=%b trig=%b expected tx=%b ready=0 trig=0",
                 i, tx_pe, ready_pe, trig_pe, exp[i/4]);
      end
    end
    @(negedge clk);
    checks++;
    if ({tx_pe, ready_pe, trig_pe} !== 3'b111) begin
      errors++;
      $display("FAIL even_end tx/ready/trig=%b expected 111", {tx_pe, ready_pe, trig_pe});
    end
  endtask

  task automatic test_parity_odd();
    logic [11:0] exp;
    exp = {2'b11, 1'b0, 8'h54, 1'b0};
    data_po  = 8'h54;
    valid_po = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      valid_po = 1'b0;
      checks++;
      if (tx_po !== exp[i/4] || ready_po !== 1'b0 || trig_po !== 1'b0) begin
        errors++;
        $display("FAIL odd_cycle[%0d] tx=%b ready=%b trig=%b expected tx=%b ready=0 trig=0",
                 i, tx_po, ready_po, trig_po, exp[i/4]);
      end
    end
    @(negedge clk);
    checks++;
    if ({tx_po, ready_po, trig_po} !== 3'b111) begin
      errors++;
      $display("FAIL odd_end tx/ready/trig=%b expected 111", {tx_po, ready_po, trig_po});
    end
  endtask

  task automatic test_data7();
    logic [8:0] exp;
    exp = {1'b1, 7'h7F, 1'b0};
    data_d7  = 7'h7F;
    valid_d7 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      valid_d7 = 1'b0;
      checks++;
      if (tx_d7 !== exp[i] || ready_d7 !== 1'b0) begin
        errors++;
        $display("FAIL d7_bit[%0d] tx=%b ready=%b expected tx=%b ready=0", i, tx_d7, ready_d7, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({tx_d7, ready_d7, trig_d7} !== 3'b111) begin
      errors++;
      $display("FAIL d7_end tx/ready/trig=%b expected 111", {tx_d7, ready_d7, trig_d7});
    end
  endtask

  task automatic test_mid_reset();
    logic [9:0] exp;
    data_def  = 8'h00;
    valid_def = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      valid_def = 1'b0;
      checks++;
      if (tx_def !== 1'b0 || ready_def !== 1'b0) begin
        errors++;
        $display("FAIL midrst_pre[%0d] tx=%b ready=%b expected tx=0 ready=0", i, tx_def, ready_def);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_def, ready_def, trig_def} !== 3'b110) begin
      errors++;
      $display("FAIL midrst_abort tx/ready/trig=%b expected 110", {tx_def, ready_def, trig_def});
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_def, ready_def, trig_def} !== 3'b110) begin
        errors++;
        $display("FAIL midrst_quiet[%0d] tx/ready/trig=%b expected 110", i, {tx_def, ready_def, trig_def});
      end
    end
    exp = {1'b1, 8'hA5, 1'b0};
    data_def  = 8'hA5;
    valid_def = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_def = 1'b0;
      checks++;
      if (tx_def !== exp[i] || ready_def !== 1'b0) begin
        errors++;
        $display("FAIL midrst_new[%0d] tx=%b ready=%b expected tx=%b ready=0", i, tx_def, ready_def, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({tx_def, ready_def, trig_def} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_new_end tx/ready/trig=%b expected 111", {tx_def, ready_def, trig_def});
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_parity_even();
    @(negedge clk);
    test_parity_odd();
    @(negedge clk);
    test_data7();
    @(negedge clk);
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
